dmem_sync: RTL and testbench

//  Clocked, parametrised data memory for the pipelined CPU's MEM stage. Successor to the combinational DMEM.

---
 rtl/dmem_sync_pkg.sv | 67 ++++++
 rtl/dmem_sync_if.sv | 24 ++
 rtl/dmem_sync_ram.sv | 24 ++
 rtl/dmem_sync.sv | 128 ++++++++++++
 tb/tb_dmem_sync.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_sync_pkg.sv
// Shared types and byte-lane helpers for the clocked data memory.
// Covers size encodings, FSM states, alignment faults, store lane placement and load extension.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10,
      SZ_RSVD = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      INIT = 2'd0,
      IDLE = 2'd1,
      BUSY = 2'd2
   } state_e;

   function automatic logic align_fault(size_e size, logic [1:0] off);
      logic f;
      case (size)
         SZ_BYTE: f = 1'b0;
         SZ_HALF: f = off[0];
         SZ_WORD: f = |off;
         default: f = 1'b1;
      endcase
      return f;
   endfunction

   function automatic logic [3:0] lane_mask(size_e size, logic [1:0] off);
      logic [3:0] m;
      case (size)
         SZ_BYTE: m = 4'b0001 << off;
         SZ_HALF: m = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: m = 4'b1111;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Replicate right-justified store data so every lane carries it; the mask picks the lane.
   function automatic logic [31:0] store_align(logic [31:0] wdata, size_e size);
      logic [31:0] w;
      case (size)
         SZ_BYTE: w = {4{wdata[7:0]}};
         SZ_HALF: w = {2{wdata[15:0]}};
         default: w = wdata;
      endcase
      return w;
   endfunction

   function automatic logic [31:0] load_extend(logic [31:0] word, size_e size,
                                               logic [1:0] off, logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{off, 3'b000} +: 8];
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
         SZ_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
         SZ_WORD: r = word;
         default: r = '0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_sync_if.sv
// Request/response bundle between the MEM stage (master) and dmem_sync (slave).
interface dmem_sync_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        init_done;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, init_done
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, init_done
   );
endinterface

// File: rtl/dmem_sync_ram.sv
// DEPTH x 32 storage with one byte-enabled write port and one registered read port.
module dmem_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [3:0]    wbe,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] mem [DEPTH];

   // NOTE: the array and read register have no reset; the post-reset fill defines the contents
   // and keeps this mappable onto block RAM.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (wbe[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/dmem_sync.sv
// Clocked data memory: pattern fill after reset, then one sized load/store at a time
// with a fixed RD_LAT-cycle response and fault reporting.
module dmem_sync
   import dmem_pkg::*;
#(
   parameter int DEPTH     = 256,
   parameter int RD_LAT    = 1,
   parameter int INIT_MODE = 1
) (
   input logic        clk,
   input logic        rst_n,
   dmem_sync_if.slave bus
);
   localparam int AW = $clog2(DEPTH);

   state_e        state;
   logic [AW-1:0] fill_cnt;
   logic [1:0]    lat_cnt;
   logic          we_q;
   logic          uns_q;
   logic          fault_q;
   size_e         size_q;
   logic [1:0]    off_q;

   size_e         size;
   logic [1:0]    off;
   logic [AW-1:0] word_idx;
   logic          accept;
   logic          fault;

   logic [3:0]    ram_be;
   logic [AW-1:0] ram_waddr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;
   logic          ram_re;

   assign size     = size_e'(bus.req_size);
   assign off      = bus.req_addr[1:0];
   assign word_idx = bus.req_addr[AW+1:2];
   assign accept   = bus.req_valid && bus.req_ready;
   assign fault    = align_fault(size, off) || (|bus.req_addr[31:AW+2]);
   assign ram_re   = accept && !bus.req_we;

   // The fill owns the write port during INIT; afterwards only clean accepted stores use it.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      ram_be    = 4'b0000;
      ram_waddr = word_idx;
      ram_wdata = store_align(bus.req_wdata, size);
      if (state == INIT) begin
         ram_be    = 4'hF;
         ram_waddr = fill_cnt;
         ram_wdata = (INIT_MODE != 0) ? 32'(fill_cnt) : 32'h0;
      end else if (accept && bus.req_we && !fault) begin
         ram_be = lane_mask(size, off);
      end
   end

   dmem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk   (clk),
      .wbe   (ram_be),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .re    (ram_re),
      .raddr (word_idx),
      .rdata (ram_rdata)
   );

   // NOTE: non-blocking assignments only, so every register here sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= INIT;
         fill_cnt      <= '0;
         lat_cnt       <= '0;
         we_q          <= 1'b0;
         uns_q         <= 1'b0;
         fault_q       <= 1'b0;
         size_q        <= SZ_WORD;
         off_q         <= 2'b00;
         bus.req_ready <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 32'h0;
         bus.rsp_fault <= 1'b0;
         bus.init_done <= 1'b0;
      end else begin
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= 32'h0;
         bus.rsp_fault <= 1'b0;
         case (state)
            INIT: begin
               fill_cnt <= fill_cnt + 1'b1;
               if (fill_cnt == AW'(DEPTH - 1)) begin
                  state         <= IDLE;
                  bus.init_done <= 1'b1;
                  bus.req_ready <= 1'b1;
               end
            end
            IDLE: begin
               if (accept) begin
                  state         <= BUSY;
                  bus.req_ready <= 1'b0;
                  lat_cnt       <= 2'(RD_LAT);
                  we_q          <= bus.req_we;
                  uns_q         <= bus.req_unsigned;
                  fault_q       <= fault;
                  size_q        <= size;
                  off_q         <= off;
               end else begin
                  bus.req_ready <= 1'b1;
               end
            end
            BUSY: begin
               // Ready stays low through the response cycle and returns in IDLE one cycle later.
               if (lat_cnt == 2'd1) begin
                  state         <= IDLE;
                  bus.rsp_valid <= 1'b1;
                  bus.rsp_fault <= fault_q;
                  bus.rsp_rdata <= (fault_q || we_q) ? 32'h0
                                   : load_extend(ram_rdata, size_q, off_q, uns_q);
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            default: state <= INIT;
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_sync.sv
// Scoreboard bench for dmem_sync: two instances (RD_LAT 1 and 2) share clock and reset;
// stimulus pushes expected responses, a negedge monitor pops and compares.
module tb_dmem_sync;
   import dmem_pkg::*;

   localparam int DEPTH = 256;
   localparam int LAT0  = 1;
   localparam int LAT1  = 2;

   typedef struct {
      logic [31:0] rdata;
      logic        fault;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  v;
   logic [1:0]  we_s;
   logic [1:0]  uns;
   logic [1:0]  sz   [2];
   logic [31:0] addr [2];
   logic [31:0] wd   [2];
   wire  [1:0]  rdy;
   wire  [1:0]  rv;
   wire  [1:0]  rf;
   wire  [1:0]  idn;
   logic [31:0] rd   [2];

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   exp_t q0[$];
   exp_t q1[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_sync_if ifa ();
   dmem_sync_if ifb ();

   assign ifa.req_valid    = v[0];
   assign ifa.req_we       = we_s[0];
   assign ifa.req_size     = sz[0];
   assign ifa.req_unsigned = uns[0];
   assign ifa.req_addr     = addr[0];
   assign ifa.req_wdata    = wd[0];
   assign ifb.req_valid    = v[1];
   assign ifb.req_we       = we_s[1];
   assign ifb.req_size     = sz[1];
   assign ifb.req_unsigned = uns[1];
   assign ifb.req_addr     = addr[1];
   assign ifb.req_wdata    = wd[1];
   assign rdy = {ifb.req_ready, ifa.req_ready};
   assign rv  = {ifb.rsp_valid, ifa.rsp_valid};
   assign rf  = {ifb.rsp_fault, ifa.rsp_fault};
   assign idn = {ifb.init_done, ifa.init_done};
   assign rd[0] = ifa.rsp_rdata;
   assign rd[1] = ifb.rsp_rdata;

   dmem_sync #(.DEPTH(DEPTH), .RD_LAT(LAT0), .INIT_MODE(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(ifa));
   dmem_sync #(.DEPTH(DEPTH), .RD_LAT(LAT1), .INIT_MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(ifb));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Response monitor: pops one expectation per rsp_valid pulse.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         exp_t e;
         int   n;
         n = (d == 0) ? q0.size() : q1.size();
         if (rv[d]) begin
            if (n == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 expected 0 (t=%0t)", d, $time);
            end else begin
               if (d == 0) e = q0.pop_front();
               else        e = q1.pop_front();
               check($sformatf("rdata dut%0d", d), rd[d], e.rdata);
               check($sformatf("fault dut%0d", d), {31'b0, rf[d]}, {31'b0, e.fault});
               check($sformatf("latency dut%0d", d), 32'(cyc - e.acc), 32'((d == 0) ? LAT0 : LAT1));
               check($sformatf("ready_at_rsp dut%0d", d), {31'b0, rdy[d]}, 32'h0);
            end
         end else begin
            check($sformatf("quiet_rdata dut%0d", d), rd[d], 32'h0);
            check($sformatf("quiet_fault dut%0d", d), {31'b0, rf[d]}, 32'h0);
            if (n > 0) begin
               if (d == 0) e = q0[0];
               else        e = q1[0];
               if (cyc >= e.acc) check($sformatf("busy_ready dut%0d", d), {31'b0, rdy[d]}, 32'h0);
            end
         end
      end
   end

   // Issue one request to dut d; returns at the negedge before the accepting posedge.
   task automatic op(input int d, input logic w, input logic [1:0] s, input logic u,
                     input logic [31:0] a, input logic [31:0] wdat,
                     input logic [31:0] er, input logic ef);
      exp_t e;
      bit   ok;
      ok = 1'b0;
      @(negedge clk);
      v       = '0;
      v[d]    = 1'b1;
      we_s[d] = w;
      sz[d]   = s;
      uns[d]  = u;
      addr[d] = a;
      wd[d]   = wdat;
      for (int k = 0; k < 700; k++) begin
         if (rdy[d]) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         check($sformatf("accept dut%0d", d), {31'b0, rdy[d]}, 32'h1);
      end else begin
         e.rdata = er;
         e.fault = ef;
         e.acc   = cyc + 1;
         if (d == 0) q0.push_back(e);
         else        q1.push_back(e);
      end
   endtask

   task automatic idle();
      @(negedge clk);
      v = '0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40; k++) begin
         if (q0.size() == 0 && q1.size() == 0) break;
         @(negedge clk);
      end
      check("drain dut0", 32'(q0.size()), 32'h0);
      check("drain dut1", 32'(q1.size()), 32'h0);
   endtask

   task automatic check_reset();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_ready dut%0d", d), {31'b0, rdy[d]}, 32'h0);
         check($sformatf("rst_valid dut%0d", d), {31'b0, rv[d]}, 32'h0);
         check($sformatf("rst_rdata dut%0d", d), rd[d], 32'h0);
         check($sformatf("rst_fault dut%0d", d), {31'b0, rf[d]}, 32'h0);
         check($sformatf("rst_init_done dut%0d", d), {31'b0, idn[d]}, 32'h0);
      end
   endtask

   // Called at a negedge; counts posedges until init_done is seen high.
   task automatic release_and_time();
      int rise [2];
      rise[0] = -1;
      rise[1] = -1;
      rst_n = 1'b1;
      for (int k = 1; k <= DEPTH + 20; k++) begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (rise[d] < 0 && idn[d]) rise[d] = k;
         end
      end
      for (int d = 0; d < 2; d++) begin
         check($sformatf("init_cycles dut%0d", d), 32'(rise[d]), 32'(DEPTH));
         check($sformatf("ready_after_init dut%0d", d), {31'b0, rdy[d]}, 32'h1);
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation still running at t=%0t", $time);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      v     = '0;
      we_s  = '0;
      uns   = '0;
      for (int d = 0; d < 2; d++) begin
         sz[d]   = SZ_WORD;
         addr[d] = 32'h0;
         wd[d]   = 32'h0;
      end
      repeat (3) @(negedge clk);
      check_reset();
      release_and_time();

      for (int d = 0; d < 2; d++) begin
         // pattern fill and range boundary
         op(d, 0, SZ_WORD, 0, 32'h18,  32'h0, 32'h6,        0);
         op(d, 0, SZ_WORD, 0, 32'h3FC, 32'h0, 32'hFF,       0);
         op(d, 0, SZ_BYTE, 1, 32'h3FC, 32'h0, 32'hFF,       0);
         op(d, 0, SZ_BYTE, 0, 32'h3FC, 32'h0, 32'hFFFFFFFF, 0);
         op(d, 0, SZ_BYTE, 1, 32'h3FF, 32'h0, 32'h0,        0);
         // word store, then sized loads of each lane
         op(d, 1, SZ_WORD, 0, 32'h40, 32'hDEADBEEF, 32'h0,  0);
         op(d, 0, SZ_WORD, 0, 32'h40, 32'h0, 32'hDEADBEEF,  0);
         op(d, 0, SZ_BYTE, 1, 32'h41, 32'h0, 32'hBE,        0);
         op(d, 0, SZ_BYTE, 0, 32'h43, 32'h0, 32'hFFFFFFDE,  0);
         op(d, 0, SZ_HALF, 1, 32'h42, 32'h0, 32'hDEAD,      0);
         op(d, 0, SZ_HALF, 0, 32'h42, 32'h0, 32'hFFFFDEAD,  0);
         op(d, 0, SZ_BYTE, 0, 32'h40, 32'h0, 32'hFFFFFFEF,  0);
         op(d, 0, SZ_HALF, 1, 32'h40, 32'h0, 32'hBEEF,      0);
         // partial stores over the pattern word 0x11
         op(d, 1, SZ_BYTE, 0, 32'h45, 32'hABCDEF12, 32'h0,  0);
         op(d, 0, SZ_WORD, 0, 32'h44, 32'h0, 32'h00001211,  0);
         op(d, 1, SZ_HALF, 0, 32'h46, 32'h1234BEEF, 32'h0,  0);
         op(d, 0, SZ_WORD, 0, 32'h44, 32'h0, 32'hBEEF1211,  0);
         op(d, 0, SZ_HALF, 0, 32'h46, 32'h0, 32'hFFFFBEEF,  0);
         // faults: misaligned, reserved size, out of range; stores must not write
         op(d, 0, SZ_WORD, 0, 32'h42,       32'h0, 32'h0, 1);
         op(d, 0, SZ_HALF, 0, 32'h01,       32'h0, 32'h0, 1);
         op(d, 0, SZ_RSVD, 0, 32'h00,       32'h0, 32'h0, 1);
         op(d, 0, SZ_WORD, 0, 32'h400,      32'h0, 32'h0, 1);
         op(d, 0, SZ_BYTE, 1, 32'h401,      32'h0, 32'h0, 1);
         op(d, 0, SZ_WORD, 0, 32'h80000000, 32'h0, 32'h0, 1);
         op(d, 1, SZ_WORD, 0, 32'h42,  32'hFFFFFFFF, 32'h0, 1);
         op(d, 1, SZ_WORD, 0, 32'h400, 32'h55555555, 32'h0, 1);
         op(d, 1, SZ_BYTE, 0, 32'h400, 32'h000000AA, 32'h0, 1);
         op(d, 1, SZ_HALF, 0, 32'h45,  32'h00007777, 32'h0, 1);
         op(d, 1, SZ_RSVD, 0, 32'h44,  32'h66666666, 32'h0, 1);
         op(d, 0, SZ_WORD, 0, 32'h40, 32'h0, 32'hDEADBEEF, 0);
         op(d, 0, SZ_WORD, 0, 32'h00, 32'h0, 32'h0,        0);
         op(d, 0, SZ_WORD, 0, 32'h44, 32'h0, 32'hBEEF1211, 0);
         idle();
         drain();
      end

      // back-to-back requests with req_valid held high
      for (int d = 0; d < 2; d++) begin
         op(d, 0, SZ_WORD, 0, 32'h18, 32'h0, 32'h6, 0);
         op(d, 0, SZ_WORD, 0, 32'h1C, 32'h0, 32'h7, 0);
         op(d, 0, SZ_BYTE, 1, 32'h20, 32'h0, 32'h8, 0);
         op(d, 0, SZ_WORD, 0, 32'h24, 32'h0, 32'h9, 0);
         idle();
         drain();
      end

      // reset while BUSY drops the response and refills the array
      op(1, 1, SZ_WORD, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0);
      @(negedge clk);
      rst_n = 1'b0;
      v     = '0;
      q0.delete();
      q1.delete();
      @(negedge clk);
      check_reset();
      @(negedge clk);
      check_reset();
      release_and_time();
      op(0, 0, SZ_WORD, 0, 32'h40, 32'h0, 32'h10, 0);
      op(1, 0, SZ_WORD, 0, 32'h40, 32'h0, 32'h10, 0);
      op(0, 0, SZ_WORD, 0, 32'h44, 32'h0, 32'h11, 0);
      idle();
      drain();
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
